// File: rtl/bitslam_synth.sv
// Multi-voice sound generator: per-voice divider, noise LFSR or square wave, volume,
// summed into a registered audio word. Configured through a 6-bit address/data bus.
module bitslam_synth #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned DIV_WIDTH  = 10,
    parameter int unsigned VOL_WIDTH  = 4,
    localparam int unsigned OUT_WIDTH = VOL_WIDTH + $clog2(NUM_VOICES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bus_sel_i,
    input  logic [5:0]           bus_data_i,
    output logic [OUT_WIDTH-1:0] audio_out_o
);

    logic [5:0]           addr_q, addr_d;
    logic [DIV_WIDTH-1:0] div_q   [NUM_VOICES];
    logic [DIV_WIDTH-1:0] div_d   [NUM_VOICES];
    logic [DIV_WIDTH-1:0] cnt_q   [NUM_VOICES];
    logic [DIV_WIDTH-1:0] cnt_d   [NUM_VOICES];
    logic [VOL_WIDTH-1:0] vol_q   [NUM_VOICES];
    logic [VOL_WIDTH-1:0] vol_d   [NUM_VOICES];
    logic [9:0]           lfsr_q  [NUM_VOICES];
    logic [9:0]           lfsr_d  [NUM_VOICES];
    logic [3:0]           mask_q  [NUM_VOICES];
    logic [3:0]           mask_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] mode_q, mode_d;
    logic [NUM_VOICES-1:0] en_q, en_d;
    logic [NUM_VOICES-1:0] phase_q, phase_d;
    logic [OUT_WIDTH-1:0] audio_q, audio_d;

    logic wr_en;
    logic tick;
    logic fb;
    logic voice_bit;

    always_comb begin
        addr_d    = bus_sel_i ? addr_q : bus_data_i;
        div_d     = div_q;
        cnt_d     = cnt_q;
        vol_d     = vol_q;
        lfsr_d    = lfsr_q;
        mask_d    = mask_q;
        mode_d    = mode_q;
        en_d      = en_q;
        phase_d   = phase_q;
        audio_d   = '0;
        tick      = 1'b0;
        fb        = 1'b0;
        voice_bit = 1'b0;
        wr_en     = bus_sel_i && !addr_q[5] && ({29'd0, addr_q[4:2]} < NUM_VOICES);

        for (int v = 0; v < NUM_VOICES; v++) begin
            // Tick and mixing use pre-edge register values, even if this edge writes them.
            tick = en_q[v] && (cnt_q[v] >= div_q[v]);
            cnt_d[v] = (tick || !en_q[v]) ? '0 : cnt_q[v] + 1'b1;
            fb = (lfsr_q[v][1] & mask_q[v][0]) ^ (lfsr_q[v][4] & mask_q[v][1]) ^
                 (lfsr_q[v][6] & mask_q[v][2]) ^ (lfsr_q[v][9] & mask_q[v][3]);
            if (tick) begin
                lfsr_d[v]  = (lfsr_q[v] == 10'd0) ? 10'd1 : {lfsr_q[v][8:0], fb};
                phase_d[v] = ~phase_q[v];
            end
            voice_bit = mode_q[v] ? phase_q[v] : lfsr_q[v][0];
            if (en_q[v] && voice_bit) begin
                audio_d = audio_d + OUT_WIDTH'(vol_q[v]);
            end

            if (wr_en && (addr_q[4:2] == 3'(v))) begin
                unique case (addr_q[1:0])
                    2'd0: div_d[v][5:0] = bus_data_i;
                    // Truncation leaves div untouched when there are no high bits.
                    2'd1: div_d[v] = DIV_WIDTH'({bus_data_i, div_q[v][5:0]});
                    2'd2: begin
                        mask_d[v] = bus_data_i[3:0];
                        mode_d[v] = bus_data_i[4];
                        en_d[v]   = bus_data_i[5];
                    end
                    default: vol_d[v] = VOL_WIDTH'(bus_data_i);
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            mode_q  <= '0;
            en_q    <= '0;
            phase_q <= '0;
            audio_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                div_q[v]  <= '0;
                cnt_q[v]  <= '0;
                vol_q[v]  <= '0;
                lfsr_q[v] <= 10'h001;
                mask_q[v] <= '0;
            end
        end else begin
            addr_q  <= addr_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            vol_q   <= vol_d;
            lfsr_q  <= lfsr_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            phase_q <= phase_d;
            audio_q <= audio_d;
        end
    end

    assign audio_out_o = audio_q;

endmodule
